// File: rtl/io_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : io_output_buffer
// Description : FIFO between CPU output stores and a slow character sink.
//               The CPU pushes words. A two-state drain FSM pops one word at a
//               time and emits it as a registered one-cycle strobe. After each
//               emitted word, DRAIN_DELAY idle cycles follow.
// Ports       : clk        - sole clock, rising edge
//               areset     - asynchronous active-high reset
//               cpu_write  - CPU store strobe, one entry per high cycle
//               cpu_data   - word stored by the CPU
//               flush      - synchronous clear of buffer and error state
//               out_enable - permits draining when high
//               cpu_stall  - buffer full, CPU must hold further writes
//               overflow   - sticky flag, a write was attempted while full
//               pending    - number of entries currently held
//               out_write  - registered one-cycle strobe to the sink
//               io_out     - word for the sink, valid with out_write
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module io_output_buffer #(
  parameter int DEPTH       = 4,
  parameter int DRAIN_DELAY = 2
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       cpu_write,
  input  logic [`WORD_SIZE-1:0]      cpu_data,
  input  logic                       flush,
  input  logic                       out_enable,
  output logic                       cpu_stall,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       out_write,
  output logic [`WORD_SIZE-1:0]      io_out
);

  localparam int c_aw = $clog2(DEPTH);
  // The hold counter needs at least one bit even when no delay is configured.
  localparam int c_cw = (DRAIN_DELAY > 0) ? $clog2(DRAIN_DELAY + 1) : 1;
  localparam logic [c_aw:0]  c_full  = (c_aw + 1)'(DEPTH);
  localparam logic [c_cw-1:0] c_delay = c_cw'(DRAIN_DELAY);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [c_cw-1:0]         cnt_q, cnt_d;
  logic [c_aw-1:0]         wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]         rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    out_write_q, out_write_d;
  logic [`WORD_SIZE-1:0]   io_out_q, io_out_d;
  logic [`WORD_SIZE-1:0]   mem_q [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Push and pop are both decided on pre-edge occupancy. A pop on the same
  // edge does not make room for a write that arrives while the buffer is full.
  assign w_full  = (count_q == c_full);
  assign w_empty = (count_q == '0);
  assign w_push  = cpu_write && !w_full && !flush;
  assign w_pop   = (state_q == IDLE) && out_enable && !w_empty && !flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_write_d = 1'b0;
    io_out_d    = io_out_q;

    if (flush) begin
      // Flush wins over a concurrent write: the word is discarded and the
      // overflow flag is not set.
      state_d    = IDLE;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (cpu_write && w_full) begin
        overflow_d = 1'b1;
      end

      // The pointers are c_aw bits wide and DEPTH is a power of two, so the
      // increment wraps from DEPTH-1 to 0 on its own.
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (w_pop) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_write_d = 1'b1;
            io_out_d    = mem_q[rd_ptr_q];
            if (DRAIN_DELAY > 0) begin
              state_d = HOLD;
              cnt_d   = c_delay;
            end
          end
        end
        HOLD: begin
          // Return to IDLE on the edge where the counter reaches zero. The
          // next word can then go out one edge later.
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= c_cw'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      out_write_q <= 1'b0;
      io_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      out_write_q <= out_write_d;
      io_out_q    <= io_out_d;
    end
  end

  // The storage array has no reset. Stale words can never be read because the
  // count and pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= cpu_data;
    end
  end

  assign cpu_stall = w_full;
  assign overflow  = overflow_q;
  assign pending   = count_q;
  assign out_write = out_write_q;
  assign io_out    = io_out_q;

endmodule

`default_nettype wire

// File: tb/tb_io_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_output_buffer
// Description : Directed self-checking bench for io_output_buffer with
//               DEPTH=4 and DRAIN_DELAY=2.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_io_output_buffer;

  logic                  clk;
  logic                  areset;
  logic                  cpu_write;
  logic [`WORD_SIZE-1:0] cpu_data;
  logic                  flush;
  logic                  out_enable;
  logic                  cpu_stall;
  logic                  overflow;
  logic [2:0]            pending;
  logic                  out_write;
  logic [`WORD_SIZE-1:0] io_out;

  int checks;
  int errors;

  io_output_buffer #(
    .DEPTH       (4),
    .DRAIN_DELAY (2)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .cpu_write  (cpu_write),
    .cpu_data   (cpu_data),
    .flush      (flush),
    .out_enable (out_enable),
    .cpu_stall  (cpu_stall),
    .overflow   (overflow),
    .pending    (pending),
    .out_write  (out_write),
    .io_out     (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move one rising edge forward, then 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset     = 1'b1;
    cpu_write  = 1'b0;
    cpu_data   = '0;
    flush      = 1'b0;
    out_enable = 1'b0;
    #2;
    checks++;
    if ({out_write, io_out, pending, overflow, cpu_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ow=%b io=%h pend=%0d ovf=%b stall=%b required all 0",
               out_write, io_out, pending, overflow, cpu_stall);
    end
    tick();
    tick();
    areset = 1'b0;
    tick();
    checks++;
    if (pending !== 3'd0 || out_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got pend=%0d ow=%b required 0 0", pending, out_write);
    end
  endtask

  task automatic test_single();
    out_enable = 1'b1;
    cpu_write  = 1'b1;
    cpu_data   = 16'h0041;
    tick();                       // edge 0: word stored
    cpu_write  = 1'b0;
    checks++;
    if (out_write !== 1'b0 || pending !== 3'd1) begin
      errors++;
      $display("FAIL single_edge0: got ow=%b pend=%0d required 0 1", out_write, pending);
    end
    tick();                       // edge 1: emitted
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0041 || pending !== 3'd0) begin
      errors++;
      $display("FAIL single_emit: got ow=%b io=%h pend=%0d required 1 0041 0",
               out_write, io_out, pending);
    end
    for (int i = 2; i < 7; i++) begin
      tick();
      checks++;
      if (out_write !== 1'b0 || io_out !== 16'h0041) begin
        errors++;
        $display("FAIL single_after edge %0d: got ow=%b io=%h required 0 0041",
                 i, out_write, io_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic                  exp_ow;
    logic [`WORD_SIZE-1:0] exp_io;
    exp_io     = 16'h0041;
    out_enable = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cpu_write = (e < 3);
      cpu_data  = 16'(16'h0061 + e);
      tick();
      exp_ow = (e == 1) || (e == 4) || (e == 7);
      if (e == 1) exp_io = 16'h0061;
      if (e == 4) exp_io = 16'h0062;
      if (e == 7) exp_io = 16'h0063;
      checks++;
      if (out_write !== exp_ow || io_out !== exp_io) begin
        errors++;
        $display("FAIL b2b edge %0d: got ow=%b io=%h required ow=%b io=%h",
                 e, out_write, io_out, exp_ow, exp_io);
      end
    end
    cpu_write = 1'b0;
    checks++;
    if (pending !== 3'd0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d required 0", pending);
    end
  endtask

  task automatic test_full();
    logic                  exp_ow;
    logic [`WORD_SIZE-1:0] exp_io;
    out_enable = 1'b0;
    for (int e = 0; e < 5; e++) begin
      cpu_write = 1'b1;
      cpu_data  = 16'(16'h0031 + e);
      tick();
      if (e == 3) begin
        checks++;
        if (pending !== 3'd4 || cpu_stall !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_edge3: got pend=%0d stall=%b ovf=%b required 4 1 0",
                   pending, cpu_stall, overflow);
        end
      end
    end
    cpu_write = 1'b0;
    checks++;
    if (pending !== 3'd4 || cpu_stall !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_edge4: got pend=%0d stall=%b ovf=%b required 4 1 1",
               pending, cpu_stall, overflow);
    end
    out_enable = 1'b1;
    tick();
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0031 || pending !== 3'd3 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL full_first_pop: got ow=%b io=%h pend=%0d stall=%b required 1 0031 3 0",
               out_write, io_out, pending, cpu_stall);
    end
    exp_io = 16'h0031;
    for (int j = 1; j < 13; j++) begin
      tick();
      exp_ow = (j % 3 == 0) && (j <= 9);
      if (exp_ow) exp_io = 16'(16'h0031 + j / 3);
      checks++;
      if (out_write !== exp_ow || io_out !== exp_io) begin
        errors++;
        $display("FAIL full_drain step %0d: got ow=%b io=%h required ow=%b io=%h",
                 j, out_write, io_out, exp_ow, exp_io);
      end
    end
    checks++;
    if (pending !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_end: got pend=%0d ovf=%b required 0 1", pending, overflow);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_clears_ovf: got %b required 0", overflow);
    end
    out_enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      cpu_write = 1'b1;
      cpu_data  = 16'(16'h0081 + e);
      tick();
    end
    cpu_write  = 1'b0;
    out_enable = 1'b1;
    tick();
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0081 || pending !== 3'd2) begin
      errors++;
      $display("FAIL flush_pre_emit: got ow=%b io=%h pend=%0d required 1 0081 2",
               out_write, io_out, pending);
    end
    flush     = 1'b1;
    cpu_write = 1'b1;
    cpu_data  = 16'h00EE;
    tick();
    flush     = 1'b0;
    cpu_write = 1'b0;
    checks++;
    if (pending !== 3'd0 || overflow !== 1'b0 || out_write !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold: got pend=%0d ovf=%b ow=%b stall=%b required 0 0 0 0",
               pending, overflow, out_write, cpu_stall);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_write !== 1'b0 || pending !== 3'd0) begin
        errors++;
        $display("FAIL flush_quiet cycle %0d: got ow=%b pend=%0d required 0 0",
                 i, out_write, pending);
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic                  exp_ow;
    logic [`WORD_SIZE-1:0] exp_io;
    out_enable = 1'b0;
    for (int e = 0; e < 4; e++) begin
      cpu_write = 1'b1;
      cpu_data  = 16'(16'h0071 + e);
      tick();
    end
    checks++;
    if (pending !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ppf_filled: got pend=%0d ovf=%b required 4 0", pending, overflow);
    end
    out_enable = 1'b1;
    cpu_write  = 1'b1;
    cpu_data   = 16'h0099;
    tick();
    cpu_write  = 1'b0;
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0071 || pending !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ppf_pop_edge: got ow=%b io=%h pend=%0d ovf=%b required 1 0071 3 1",
               out_write, io_out, pending, overflow);
    end
    exp_io = 16'h0071;
    for (int j = 1; j < 11; j++) begin
      tick();
      exp_ow = (j % 3 == 0) && (j <= 9);
      if (exp_ow) exp_io = 16'(16'h0071 + j / 3);
      checks++;
      if (out_write !== exp_ow || io_out !== exp_io) begin
        errors++;
        $display("FAIL ppf_drain step %0d: got ow=%b io=%h required ow=%b io=%h",
                 j, out_write, io_out, exp_ow, exp_io);
      end
    end
  endtask

  task automatic test_async_reset();
    out_enable = 1'b1;
    cpu_write  = 1'b1;
    cpu_data   = 16'h0055;
    tick();
    cpu_data   = 16'h0056;
    tick();
    cpu_write  = 1'b0;
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0055 || pending !== 3'd1) begin
      errors++;
      $display("FAIL areset_pre: got ow=%b io=%h pend=%0d required 1 0055 1",
               out_write, io_out, pending);
    end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if ({out_write, io_out, pending, overflow, cpu_stall} !== '0) begin
      errors++;
      $display("FAIL areset_async: got ow=%b io=%h pend=%0d ovf=%b stall=%b required all 0",
               out_write, io_out, pending, overflow, cpu_stall);
    end
    tick();
    tick();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_write !== 1'b0 || io_out !== 16'h0000 || pending !== 3'd0) begin
        errors++;
        $display("FAIL areset_quiet cycle %0d: got ow=%b io=%h pend=%0d required 0 0000 0",
                 i, out_write, io_out, pending);
      end
    end
    cpu_write = 1'b1;
    cpu_data  = 16'h0077;
    tick();
    cpu_write = 1'b0;
    tick();
    checks++;
    if (out_write !== 1'b1 || io_out !== 16'h0077) begin
      errors++;
      $display("FAIL areset_new_write: got ow=%b io=%h required 1 0077", out_write, io_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_flush();
    test_push_pop_full();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
